// File: rtl/pci_target.sv
// pci_target: simplified 32-bit PCI target backed by a four-word memory.
// It claims read/write bursts whose address matches DEVICE_ADDRESS[31:4].
// It completes each data phase with DEVSEL/TRDY, stores write data under the
// byte enables, and returns the stored words on reads.
//
// Ports
//   CLK     in     1   clock, rising edge
//   RST_N   in     1   asynchronous active-low reset (also clears the memory)
//   FRAME   in     1   active-low; high during the final data phase
//   IRDY    in     1   active-low initiator ready
//   CBE     in     4   command (address phase) / active-low byte enables (data)
//   AD      inout  32  address/data; driven here only in READ_DATA
//   DEVSEL  out    1   active-low device select (registered)
//   TRDY    out    1   active-low target ready (registered)
//   DEBUG   out    32  [1:0] word ptr, [4:2] state code, [8] latched cmd is write
//   M1..M4  out    32  contents of mem[0]..mem[3]
module pci_target #(
  parameter logic [31:0] DEVICE_ADDRESS = 32'h0000_0010,
  parameter int          MEM_DEPTH      = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FRAME,
  input  logic        IRDY,
  input  logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  output logic        DEVSEL,
  output logic        TRDY,
  output logic [31:0] DEBUG,
  output logic [31:0] M1,
  output logic [31:0] M2,
  output logic [31:0] M3,
  output logic [31:0] M4
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_DATA = 2'd1,
    READ_TA    = 2'd2,
    READ_DATA  = 2'd3
  } state_e;

  localparam logic [3:0] CMD_READ  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0011;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic        devsel_q, devsel_d;
  logic        trdy_q, trdy_d;
  logic        wr_en;
  logic        addr_hit;
  logic [31:0] mem_q [MEM_DEPTH];

  assign addr_hit = (AD[31:4] == DEVICE_ADDRESS[31:4]);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cmd_wr_d = cmd_wr_q;
    devsel_d = devsel_q;
    trdy_d   = trdy_q;
    wr_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Address phase: master owns the bus (FRAME low) but IRDY is still high.
        if (!FRAME && IRDY && addr_hit && (CBE == CMD_WRITE || CBE == CMD_READ)) begin
          cmd_wr_d = (CBE == CMD_WRITE);
          ptr_d    = AD[3:2];
          devsel_d = 1'b0;
          if (CBE == CMD_WRITE) begin
            state_d = WRITE_DATA;
            trdy_d  = 1'b0;
          end else begin
            // Reads need one turnaround cycle before the target drives AD.
            state_d = READ_TA;
            trdy_d  = 1'b1;
          end
        end
      end

      READ_TA: begin
        if (FRAME && IRDY) begin
          state_d  = IDLE;
          devsel_d = 1'b1;
          trdy_d   = 1'b1;
        end else begin
          state_d = READ_DATA;
          trdy_d  = 1'b0;
        end
      end

      WRITE_DATA, READ_DATA: begin
        if (FRAME && IRDY) begin
          // Master abort: drop the burst without a transfer.
          state_d  = IDLE;
          devsel_d = 1'b1;
          trdy_d   = 1'b1;
        end else if (!IRDY && !trdy_q) begin
          wr_en = (state_q == WRITE_DATA);
          ptr_d = ptr_q + 2'd1;  // wraps 3 -> 0, older words get overwritten
          if (FRAME) begin
            state_d  = IDLE;
            devsel_d = 1'b1;
            trdy_d   = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      cmd_wr_q <= 1'b0;
      devsel_q <= 1'b1;
      trdy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cmd_wr_q <= cmd_wr_d;
      devsel_q <= devsel_d;
      trdy_q   <= trdy_d;
    end
  end

  // NOTE: this memory is deliberately reset, because a reset must discard all stored and partial data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (!CBE[b]) mem_q[ptr_q][8*b +: 8] <= AD[8*b +: 8];
      end
    end
  end

  assign AD     = (state_q == READ_DATA) ? mem_q[ptr_q] : {32{1'bz}};
  assign DEVSEL = devsel_q;
  assign TRDY   = trdy_q;
  assign DEBUG  = {23'd0, cmd_wr_q, 3'd0, 1'b0, state_q, ptr_q};
  assign M1     = mem_q[0];
  assign M2     = mem_q[1];
  assign M3     = mem_q[2];
  assign M4     = mem_q[3];

endmodule

// File: tb/tb_pci_target.sv
// tb_pci_target: randomized and directed bursts against a word-array model of
// the target. Read data expected per transfer is queued by the stimulus.
// A monitor pops the queue and compares whenever a read transfer is presented.
module tb_pci_target;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        FRAME;
  logic        IRDY;
  logic [3:0]  CBE;
  logic [31:0] ad_drv;
  logic        ad_oe;
  wire  [31:0] AD;
  logic        DEVSEL;
  logic        TRDY;
  logic [31:0] DEBUG;
  logic [31:0] M1, M2, M3, M4;

  assign AD = ad_oe ? ad_drv : {32{1'bz}};

  pci_target dut (
    .CLK(CLK), .RST_N(RST_N), .FRAME(FRAME), .IRDY(IRDY), .CBE(CBE), .AD(AD),
    .DEVSEL(DEVSEL), .TRDY(TRDY), .DEBUG(DEBUG),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the target as four words, a word pointer and the last command.
  logic [31:0] model_mem [4];
  logic [1:0]  model_ptr;
  logic        model_cmd_wr;
  logic [31:0] exp_q [$];
  bit          rd_active;

  // Optional fixed data/byte enables for directed bursts.
  bit          use_fixed;
  logic [31:0] fdata [8];
  logic [3:0]  fbe   [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] idle_debug();
    return (model_cmd_wr ? 32'h100 : 32'h0) + 32'(model_ptr);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_mem[i] = '0;
    model_ptr    = '0;
    model_cmd_wr = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    check({tag, "_M1"}, M1, model_mem[0]);
    check({tag, "_M2"}, M2, model_mem[1]);
    check({tag, "_M3"}, M3, model_mem[2]);
    check({tag, "_M4"}, M4, model_mem[3]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_devsel"}, 32'(DEVSEL), 32'd1);
    check({tag, "_trdy"},   32'(TRDY),   32'd1);
    check({tag, "_debug"},  DEBUG,       idle_debug());
  endtask

  task automatic bus_idle();
    FRAME = 1'b1;
    IRDY  = 1'b1;
    CBE   = 4'hF;
    ad_oe = 1'b0;
  endtask

  // One complete burst: address phase, n data phases (optionally with wait states), idle.
  task automatic do_burst(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                          input int wait_pct);
    bit          claimed;
    bit          is_wr;
    logic [31:0] data;
    logic [3:0]  be;
    claimed = ((addr >> 4) == (32'h10 >> 4)) && (cmd == 4'b0011 || cmd == 4'b0010);
    is_wr   = (cmd == 4'b0011);

    @(negedge CLK);
    FRAME = 1'b0; IRDY = 1'b1; CBE = cmd; ad_oe = 1'b1; ad_drv = addr;

    if (!claimed) begin
      @(negedge CLK);
      bus_idle();
      for (int k = 0; k < 3; k++) begin
        check("noclaim_devsel", 32'(DEVSEL), 32'd1);
        check("noclaim_debug", DEBUG, idle_debug());
        @(negedge CLK);
      end
      check_mem("noclaim");
      return;
    end

    model_ptr    = addr[3:2];
    model_cmd_wr = is_wr;

    if (!is_wr) begin
      @(negedge CLK);
      check("ta_devsel", 32'(DEVSEL), 32'd0);
      check("ta_trdy", 32'(TRDY), 32'd1);
      check("ta_state", 32'(DEBUG[4:2]), 32'd2);
      ad_oe = 1'b0; FRAME = 1'b0; IRDY = 1'b0;
      rd_active = 1'b1;
    end

    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < wait_pct) begin
        @(negedge CLK);
        FRAME = 1'b0; IRDY = 1'b1; CBE = 4'($urandom); ad_drv = $urandom;
        check("wait_trdy", 32'(TRDY), 32'd0);
        if (!is_wr) check("wait_ad", AD, model_mem[model_ptr]);
      end
      @(negedge CLK);
      data = use_fixed ? fdata[i] : $urandom;
      be   = use_fixed ? fbe[i]   : 4'($urandom);
      FRAME = (i == n - 1);
      IRDY  = 1'b0;
      CBE   = is_wr ? be : 4'h0;
      if (is_wr) begin
        ad_oe = 1'b1; ad_drv = data;
      end
      check("xfer_trdy", 32'(TRDY), 32'd0);
      check("xfer_devsel", 32'(DEVSEL), 32'd0);
      if (is_wr) begin
        for (int b = 0; b < 4; b++)
          if (!be[b]) model_mem[model_ptr][8*b +: 8] = data[8*b +: 8];
      end else begin
        exp_q.push_back(model_mem[model_ptr]);
      end
      model_ptr = model_ptr + 2'd1;
    end

    @(negedge CLK);
    bus_idle();
    rd_active = 1'b0;
    check_idle("end");
    check_mem("end");
  endtask

  // Monitor: a read transfer is presented whenever IRDY and TRDY are both low.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (rd_active && !IRDY && !TRDY) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_unexpected: got %h expected none", AD);
        end else begin
          check("rd_data", AD, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_active = 1'b0;
    use_fixed = 1'b0;
    ad_drv    = '0;
    bus_idle();
    RST_N = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    check_idle("reset");
    check_mem("reset");
    RST_N = 1'b1;

    // Directed write burst with alternating byte enables.
    use_fixed = 1'b1;
    fdata[0] = 32'h1001; fdata[1] = 32'h1002; fdata[2] = 32'h1003; fdata[3] = 32'h1004;
    fbe[0] = 4'b0000; fbe[1] = 4'b1111; fbe[2] = 4'b0000; fbe[3] = 4'b1111;
    do_burst(32'h10, 4'b0011, 4, 0);
    check("t1_M1", M1, 32'h1001);
    check("t1_M2", M2, 32'h0);
    check("t1_M3", M3, 32'h1003);
    check("t1_M4", M4, 32'h0);

    // Read back, with forced wait states.
    do_burst(32'h10, 4'b0010, 4, 100);

    // Non-matching address and unsupported command.
    do_burst(32'h20, 4'b0011, 2, 0);
    do_burst(32'h10, 4'b0110, 2, 0);

    // Five-word write wraps the pointer.
    for (int i = 0; i < 5; i++) begin
      fdata[i] = 32'(i + 1);
      fbe[i] = 4'b0000;
    end
    do_burst(32'h10, 4'b0011, 5, 0);
    check("t4_M1", M1, 32'd5);
    check("t4_M2", M2, 32'd2);
    check("t4_M3", M3, 32'd3);
    check("t4_M4", M4, 32'd4);
    use_fixed = 1'b0;

    // Master abort during read turnaround.
    @(negedge CLK);
    FRAME = 1'b0; IRDY = 1'b1; CBE = 4'b0010; ad_oe = 1'b1; ad_drv = 32'h14;
    @(negedge CLK);
    check("abort_ta_devsel", 32'(DEVSEL), 32'd0);
    bus_idle();
    model_ptr = 2'd1;
    model_cmd_wr = 1'b0;
    @(negedge CLK);
    check_idle("abort");
    check_mem("abort");

    // Randomized bursts.
    for (int it = 0; it < 30; it++) begin
      logic [31:0] a;
      logic [3:0]  c;
      int          sel;
      sel = $urandom_range(0, 9);
      a   = (sel < 8) ? (32'h10 | 32'($urandom_range(0, 15))) : $urandom;
      sel = $urandom_range(0, 9);
      c   = (sel < 4) ? 4'b0011 : (sel < 8) ? 4'b0010 : 4'($urandom);
      do_burst(a, c, $urandom_range(1, 6), 30);
    end

    // Reset in the middle of a read burst.
    @(negedge CLK);
    FRAME = 1'b0; IRDY = 1'b1; CBE = 4'b0010; ad_oe = 1'b1; ad_drv = 32'h18;
    @(negedge CLK);
    ad_oe = 1'b0; IRDY = 1'b0;
    @(negedge CLK);
    IRDY = 1'b1;
    check("rst_pre_state", 32'(DEBUG[4:2]), 32'd3);
    #1 RST_N = 1'b0;
    #1;
    model_reset();
    check_idle("rst_mid");
    check_mem("rst_mid");
    @(negedge CLK);
    bus_idle();
    RST_N = 1'b1;
    do_burst(32'h10, 4'b0010, 3, 0);

    check("rd_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
